cla_prefix_seq_adder: RTL and testbench

// - Multi-cycle parallel-prefix (Kogge-Stone) adder: one prefix level per clock over a single row of cla_gen_prop cells.
// - Replaces a fully unrolled LEVELS-deep prefix tree with a time-shared row, trading latency for area.
// - Sits between an operand producer and a result consumer; valid/ready handshake on both sides.

---
 rtl/cla_prefix_seq_adder_pkg.sv | 22 ++
 rtl/cla_prefix_seq_adder_row.sv | 58 +++++
 rtl/cla_prefix_seq_adder.sv | 119 +++++++++++
 tb/tb_cla_prefix_seq_adder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cla_prefix_seq_adder_pkg.sv
// Shared types and helpers for the time-shared Kogge-Stone adder.
// State encodings and a constant log2 used to size the prefix level count.
package cla_prefix_seq_adder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PREP  = 3'd1,
      ST_LEVEL = 3'd2,
      ST_SUM   = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < n) r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/cla_prefix_seq_adder_row.sv
// One Kogge-Stone prefix level as a combinational row of generate/propagate cells.
// The active span is picked by a one-hot select; bits below the span pass through.
module cla_gen_prop (
   input  logic g_hi_i,
   input  logic p_hi_i,
   input  logic g_lo_i,
   input  logic p_lo_i,
   output logic g_o,
   output logic p_o
);
   assign g_o = g_hi_i | (p_hi_i & g_lo_i);
   assign p_o = p_hi_i & p_lo_i;
endmodule

module cla_prefix_row #(
   parameter int WIDTH  = 16,
   parameter int LEVELS = 4
) (
   input  logic [WIDTH-1:0]  g_i,
   input  logic [WIDTH-1:0]  p_i,
   input  logic [LEVELS-1:0] span_sel_i,
   output logic [WIDTH-1:0]  g_o,
   output logic [WIDTH-1:0]  p_o
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [LEVELS-1:0] lo_g, lo_p, lo_en;
      logic g_lo, p_lo, active, g_c, p_c;

      // Each bit only taps partners that exist for that span; missing taps read as disabled.
      for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
         if (i >= (1 << l)) begin : g_tap
            assign lo_g[l]  = g_i[i-(1<<l)];
            assign lo_p[l]  = p_i[i-(1<<l)];
            assign lo_en[l] = span_sel_i[l];
         end else begin : g_none
            assign lo_g[l]  = 1'b0;
            assign lo_p[l]  = 1'b0;
            assign lo_en[l] = 1'b0;
         end
      end

      assign active = |lo_en;
      assign g_lo   = |(lo_g & lo_en);
      assign p_lo   = |(lo_p & lo_en);

      cla_gen_prop u_cell (
         .g_hi_i (g_i[i]),
         .p_hi_i (p_i[i]),
         .g_lo_i (g_lo),
         .p_lo_i (p_lo),
         .g_o    (g_c),
         .p_o    (p_c)
      );

      assign g_o[i] = active ? g_c : g_i[i];
      assign p_o[i] = active ? p_c : p_i[i];
   end
endmodule

// File: rtl/cla_prefix_seq_adder.sv
// Multi-cycle parallel-prefix adder: one Kogge-Stone level per clock over a shared row.
// Valid/ready on both sides; abort cancels the operation in flight.
module cla_prefix_seq_adder
   import cla_prefix_seq_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);
   localparam int LEVELS = clog2(WIDTH);
   localparam int KW     = (LEVELS > 1) ? clog2(LEVELS) : 1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, g_q, p_q, psave_q, sum_q;
   logic             cin_q, cout_q, out_valid_q;
   logic [KW-1:0]    k_q;

   logic [WIDTH-1:0]  prop, prep_g, row_g, row_p, carry;
   logic [LEVELS-1:0] span_sel;
   logic              last_level;

   assign prop       = a_q ^ b_q;
   // Carry-in folds into bit 0 so the prefix tree never needs a separate cin path.
   assign prep_g     = (a_q & b_q) | WIDTH'(prop[0] & cin_q);
   assign span_sel   = LEVELS'(1) << k_q;
   assign last_level = (k_q == KW'(LEVELS - 1));
   assign carry      = {g_q[WIDTH-2:0], cin_q};

   cla_prefix_row #(
      .WIDTH  (WIDTH),
      .LEVELS (LEVELS)
   ) u_row (
      .g_i        (g_q),
      .p_i        (p_q),
      .span_sel_i (span_sel),
      .g_o        (row_g),
      .p_o        (row_p)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (in_valid && !abort) state_d = ST_PREP;
         ST_PREP:  state_d = abort ? ST_IDLE : ST_LEVEL;
         ST_LEVEL: begin
            if (abort)           state_d = ST_IDLE;
            else if (last_level) state_d = ST_SUM;
         end
         ST_SUM:   state_d = abort ? ST_IDLE : ST_DONE;
         // abort wins over a same-cycle handshake
         ST_DONE:  if (abort || out_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         cin_q       <= 1'b0;
         g_q         <= '0;
         p_q         <= '0;
         psave_q     <= '0;
         k_q         <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= (state_d == ST_DONE);
         case (state_q)
            ST_IDLE: begin
               if (state_d == ST_PREP) begin
                  a_q   <= a;
                  b_q   <= b;
                  cin_q <= cin;
               end
            end
            ST_PREP: begin
               g_q     <= prep_g;
               p_q     <= prop;
               psave_q <= prop;
               k_q     <= '0;
            end
            ST_LEVEL: begin
               g_q <= row_g;
               p_q <= row_p;
               k_q <= k_q + KW'(1);
            end
            ST_SUM: begin
               if (state_d == ST_DONE) begin
                  sum_q  <= psave_q ^ carry;
                  cout_q <= g_q[WIDTH-1];
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
endmodule

// File: tb/tb_cla_prefix_seq_adder.sv
// Directed-vector and corner-sequence bench for the sequential prefix adder (WIDTH=16).
module tb_cla_prefix_seq_adder;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, cin, abort, out_valid, out_ready, cout, busy;
   logic [W-1:0] a, b, sum;
   int           n_checks = 0;
   int           n_errors = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
   } vec_t;

   vec_t vecs [11];

   always #5 clk = ~clk;

   cla_prefix_seq_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .abort     (abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Called at #1 after a rising edge with the DUT idle. abort_at=e pulses abort
   // before the e-th edge after acceptance (1=PREP, 2..5=LEVEL k0..3, 6=SUM).
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input int abort_at, input int stall, input string nm);
      logic [W:0] exp;
      bit         seen, aborted, rose;
      int         lat;
      exp = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
      check({nm, " in_ready_idle"}, in_ready, 1);
      a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = (stall == 0);
      @(posedge clk); #1;
      in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
      check({nm, " busy_after_accept"}, busy, 1);
      seen = 0; aborted = 0; lat = 0;
      for (int e = 1; e <= 20; e++) begin
         if (e == abort_at) abort = 1'b1;
         @(posedge clk); #1;
         abort = 1'b0;
         lat = e;
         if (e == abort_at) begin aborted = 1; break; end
         if (out_valid) begin seen = 1; break; end
      end
      if (aborted) begin
         check({nm, " abort_in_ready"}, in_ready, 1);
         check({nm, " abort_busy"}, busy, 0);
         rose = 0;
         repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) rose = 1;
         end
         check({nm, " abort_no_valid"}, rose, 0);
      end else begin
         check({nm, " out_valid_seen"}, seen, 1);
         check({nm, " latency"}, lat, 6);
         check({nm, " sum"}, sum, exp[W-1:0]);
         check({nm, " cout"}, cout, exp[W]);
         check({nm, " busy_done"}, busy, 1);
         for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check({nm, " stall_valid"}, out_valid, 1);
            check({nm, " stall_sum"}, {cout, sum}, exp);
            check({nm, " stall_in_ready"}, in_ready, 0);
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         check({nm, " hs_valid_low"}, out_valid, 0);
         check({nm, " hs_in_ready"}, in_ready, 1);
         check({nm, " hs_busy"}, busy, 0);
      end
   endtask

   initial begin
      vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vecs[1]  = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
      vecs[2]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
      vecs[3]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
      vecs[4]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      vecs[5]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
      vecs[6]  = '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0};
      vecs[7]  = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1};
      vecs[8]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
      vecs[9]  = '{16'h1234, 16'hEDCB, 1'b0, 16'hFFFF, 1'b0};
      vecs[10] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", out_valid, 0);
      check("reset sum", sum, 0);
      check("reset cout", cout, 0);
      check("reset busy", busy, 0);
      check("reset in_ready", in_ready, 1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table-driven vectors, each sum and cout hand-computed.
      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 0, (i == 1) ? 10 : 0, $sformatf("vec%0d", i));
         check($sformatf("vec%0d sum_tbl", i), sum, vecs[i].sum);
         check($sformatf("vec%0d cout_tbl", i), cout, vecs[i].cout);
      end

      // Abort in LEVEL k=1, then a clean op.
      run_op(16'h1234, 16'h0001, 1'b0, 3, 0, "abort_l1");
      run_op(16'h00FF, 16'h0001, 1'b0, 0, 0, "post_abort");
      check("post_abort sum_exact", sum, 16'h0100);

      // Abort in DONE beats a same-cycle handshake.
      out_ready = 1'b0;
      a = 16'h0F0F; b = 16'h0101; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      begin
         bit got;
         got = 0;
         for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (out_valid) begin got = 1; break; end
         end
         check("done_abort reached_done", got, 1);
      end
      check("done_abort sum", sum, 16'h1010);
      abort = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("done_abort valid_low", out_valid, 0);
      check("done_abort in_ready", in_ready, 1);

      // Abort and in_valid together in IDLE: nothing accepted.
      a = 16'h0001; b = 16'h0001; in_valid = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; abort = 1'b0;
      check("idle_abort not_accepted", busy, 0);

      // Asynchronous reset mid-LEVEL.
      a = 16'h5A5A; b = 16'hA5A5; cin = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst out_valid", out_valid, 0);
      check("async_rst busy", busy, 0);
      check("async_rst in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op(16'h8000, 16'h8000, 1'b0, 0, 0, "post_rst");

      // Random ops with stalls and occasional aborts; reference is plain a+b+cin.
      for (int n = 0; n < 300; n++) begin
         int ab;
         ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 6)) : 0;
         run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), ab,
                int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
